fetch_unit: RTL and testbench

Instruction-fetch stage of the `Risc` core. It owns the program counter, drives the synchronous instruction-memory read port and delivers `{ir, pc}` pairs to decode through a registered valid/stall interface. It also detects the end-of-program marker and raises the `halt` output that the top-level bench waits on.

---
 rtl/risc_pkg.sv | 33 +++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// risc_pkg: shared widths, opcodes, halt marker and fetch FSM states for the Risc core
package risc_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_LD,
    OP_ST,
    OP_BZ,
    OP_JMP
  } opcode_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_RUN,
    F_DRAIN,
    F_HALTED
  } fetch_state_t;

  // Word-address increment; wraps silently at the top of the address space.
  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC ownership, 1-cycle imem read, registered {ir,pc} delivery and halt detection
module fetch_unit
  import risc_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
  parameter logic [INSTR_W-1:0] HALT_WORD    = risc_pkg::HALT_WORD,
  parameter logic [3:0]         DRAIN_CYCLES = 4'd4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  im_addr,
  output logic               im_oen,
  output logic               im_wen,
  input  logic [INSTR_W-1:0] im_dataout,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_ir,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               halt
);

  fetch_state_t      state, state_nx;
  logic [ADDR_W-1:0] fetch_pc, req_pc;
  logic              req_valid;
  logic [3:0]        drain_cnt;
  logic              run, drain, freeze, start, do_redir, do_adv, capture;

  // Decode this cycle's action and the next FSM state; redirect beats freeze beats advance.
  always_comb begin
    run      = state == F_RUN;
    drain    = state == F_DRAIN;
    freeze   = stall | ~en;
    start    = (state == F_IDLE) & en;
    do_redir = (run | drain) & redirect;
    do_adv   = run & ~redirect & ~freeze;
    capture  = do_adv & req_valid & (im_dataout == HALT_WORD);
    state_nx = start ? F_RUN :
               capture ? F_DRAIN :
               do_redir ? F_RUN :
               (drain && drain_cnt <= 4'd1) ? F_HALTED : state;
  end

  // Re-presenting req_pc while frozen keeps im_dataout valid for the release cycle.
  assign im_addr = do_redir ? redirect_pc : (run & freeze) ? req_pc : fetch_pc;
  assign im_oen  = ~(run | do_redir);
  assign im_wen  = 1'b1;
  assign halt    = state == F_HALTED;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= F_IDLE;
    else        state <= state_nx;
  end

  // Drain counter: loaded on halt capture, cleared on wrong-path recovery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        drain_cnt <= '0;
    else if (capture)  drain_cnt <= DRAIN_CYCLES;
    else if (do_redir) drain_cnt <= '0;
    else if (drain)    drain_cnt <= drain_cnt - 4'd1;
  end

  // Fetch pipeline: fetch_pc -> req_pc (in memory) -> if_* (to decode).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= '0;
      req_pc    <= '0;
      req_valid <= 1'b0;
      if_valid  <= 1'b0;
      if_ir     <= '0;
      if_pc     <= '0;
    end else if (start) begin
      fetch_pc  <= RESET_PC;
      req_valid <= 1'b0;
    end else if (do_redir) begin
      if_valid  <= 1'b0;
      req_pc    <= redirect_pc;
      req_valid <= 1'b1;
      fetch_pc  <= pc_next(redirect_pc);
    end else if (do_adv) begin
      if_ir     <= im_dataout;
      if_pc     <= req_pc;
      if_valid  <= req_valid & ~capture;
      req_pc    <= fetch_pc;
      req_valid <= 1'b1;
      fetch_pc  <= pc_next(fetch_pc);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against an external synchronous memory model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, en, stall, redirect;
  logic [31:0] redirect_pc, im_addr, im_dataout, if_ir, if_pc;
  logic        im_oen, im_wen, if_valid, halt;
  logic [31:0] mem [0:63];
  int          checks = 0;
  int          errors = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_addr(im_addr), .im_oen(im_oen), .im_wen(im_wen),
    .im_dataout(im_dataout), .if_valid(if_valid), .if_ir(if_ir), .if_pc(if_pc), .halt(halt)
  );

  always #5 clk = ~clk;

  // Synchronous read memory, one cycle latency, output held when not enabled.
  initial im_dataout = 32'h0;
  always @(posedge clk) if (!im_oen) im_dataout <= mem[im_addr[5:0]];

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge where if_pc=0 is first valid.
  task automatic start_run();
    do_reset();
    en = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(negedge clk); @(negedge clk);
    checks++; if (im_addr !== 32'h0) begin errors++; $display("FAIL reset_im_addr got %h want 0", im_addr); end
    checks++; if (im_oen !== 1'b1) begin errors++; $display("FAIL reset_im_oen got %b want 1", im_oen); end
    checks++; if (im_wen !== 1'b1) begin errors++; $display("FAIL reset_im_wen got %b want 1", im_wen); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %b want 0", if_valid); end
    checks++; if (if_ir !== 32'h0) begin errors++; $display("FAIL reset_if_ir got %h want 0", if_ir); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc got %h want 0", if_pc); end
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b want 0", halt); end
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (im_oen !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL idle_without_en got oen=%b valid=%b want 1 0", im_oen, if_valid); end
  endtask

  task automatic test_straight_line();
    do_reset();
    en = 1'b1;
    @(negedge clk);
    checks++; if (im_addr !== 32'h0 || im_oen !== 1'b0) begin errors++; $display("FAIL first_addr got %h oen=%b want 0 0", im_addr, im_oen); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || im_addr !== 32'h1) begin errors++; $display("FAIL first_bubble got valid=%b addr=%h want 0 1", if_valid, im_addr); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(k) || if_ir !== 32'h1000_0000 + 32'(k)) begin
        errors++; $display("FAIL straight_%0d got v=%b pc=%h ir=%h want 1 %h %h", k, if_valid, if_pc, if_ir, k, 32'h1000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_stall();
    start_run();
    @(negedge clk);
    checks++; if (if_pc !== 32'h1 || if_valid !== 1'b1) begin errors++; $display("FAIL stall_setup got pc=%h v=%b want 1 1", if_pc, if_valid); end
    stall = 1'b1;
    #1;
    checks++; if (im_addr !== 32'h2) begin errors++; $display("FAIL stall_addr_now got %h want 2", im_addr); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h1 || if_ir !== 32'h1000_0001 || im_addr !== 32'h2) begin
        errors++; $display("FAIL stall_hold_%0d got v=%b pc=%h ir=%h addr=%h want 1 1 10000001 2", k, if_valid, if_pc, if_ir, im_addr);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h2 || if_ir !== 32'h1000_0002) begin errors++; $display("FAIL stall_release got v=%b pc=%h ir=%h want 1 2 10000002", if_valid, if_pc, if_ir); end
    @(negedge clk);
    checks++; if (if_pc !== 32'h3 || if_ir !== 32'h1000_0003) begin errors++; $display("FAIL stall_after got pc=%h ir=%h want 3 10000003", if_pc, if_ir); end
  endtask

  task automatic test_redirect_stall();
    start_run();
    redirect = 1'b1; redirect_pc = 32'd40; stall = 1'b1;
    #1;
    checks++; if (im_addr !== 32'd40 || im_oen !== 1'b0) begin errors++; $display("FAIL redir_addr got %h oen=%b want 28 0", im_addr, im_oen); end
    @(negedge clk);
    redirect = 1'b0; stall = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got %b want 0", if_valid); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'd40 || if_ir !== 32'h1000_0028) begin errors++; $display("FAIL redir_target got v=%b pc=%h ir=%h want 1 28 10000028", if_valid, if_pc, if_ir); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'd41 || if_ir !== 32'h1000_0029) begin errors++; $display("FAIL redir_next got v=%b pc=%h ir=%h want 1 29 10000029", if_valid, if_pc, if_ir); end
  endtask

  task automatic test_pc_wrap();
    start_run();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFF || if_ir !== 32'h1000_003F) begin errors++; $display("FAIL wrap_top got v=%b pc=%h ir=%h want 1 ffffffff 1000003f", if_valid, if_pc, if_ir); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_ir !== 32'h1000_0000) begin errors++; $display("FAIL wrap_zero got v=%b pc=%h ir=%h want 1 0 10000000", if_valid, if_pc, if_ir); end
  endtask

  task automatic test_halt();
    mem[5] = 32'hFFFF_FFFF;
    start_run();
    for (int k = 1; k < 5; k++) @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin errors++; $display("FAIL halt_last got v=%b pc=%h want 1 4", if_valid, if_pc); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || im_oen !== 1'b1 || halt !== 1'b0) begin errors++; $display("FAIL halt_capture got v=%b oen=%b halt=%b want 0 1 0", if_valid, im_oen, halt); end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      checks++; if (halt !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL halt_early_%0d got halt=%b v=%b want 0 0", k, halt, if_valid); end
    end
    @(negedge clk);
    checks++; if (halt !== 1'b1 || im_oen !== 1'b1) begin errors++; $display("FAIL halt_rise got halt=%b oen=%b want 1 1", halt, im_oen); end
    redirect = 1'b1; redirect_pc = 32'd20;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (halt !== 1'b1 || im_oen !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL halt_sticky_%0d got halt=%b oen=%b v=%b want 1 1 0", k, halt, im_oen, if_valid); end
    end
    redirect = 1'b0;
    mem[5] = 32'h1000_0005;
  endtask

  task automatic test_wrong_path_halt();
    mem[5] = 32'hFFFF_FFFF;
    start_run();
    for (int k = 1; k < 5; k++) @(negedge clk);
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || im_oen !== 1'b1) begin errors++; $display("FAIL wp_capture got v=%b oen=%b want 0 1", if_valid, im_oen); end
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'd10;
    #1;
    checks++; if (im_addr !== 32'd10 || im_oen !== 1'b0) begin errors++; $display("FAIL wp_redir_addr got %h oen=%b want a 0", im_addr, im_oen); end
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (if_valid !== 1'b0 || halt !== 1'b0) begin errors++; $display("FAIL wp_bubble got v=%b halt=%b want 0 0", if_valid, halt); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'd10 || if_ir !== 32'h1000_000A) begin errors++; $display("FAIL wp_target got v=%b pc=%h ir=%h want 1 a 1000000a", if_valid, if_pc, if_ir); end
    for (int k = 1; k < 7; k++) begin
      @(negedge clk);
      checks++; if (halt !== 1'b0 || if_pc !== 32'd10 + 32'(k)) begin errors++; $display("FAIL wp_run_%0d got halt=%b pc=%h want 0 %h", k, halt, if_pc, 32'd10 + 32'(k)); end
    end
    mem[5] = 32'h1000_0005;
  endtask

  task automatic test_reset_mid_run();
    start_run();
    for (int k = 0; k < 7; k++) @(negedge clk);
    checks++; if (if_pc !== 32'h7 || if_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got pc=%h v=%b want 7 1", if_pc, if_valid); end
    #2 rst_n = 1'b0; en = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_ir !== 32'h0 || im_oen !== 1'b1 || im_addr !== 32'h0 || halt !== 1'b0) begin
      errors++; $display("FAIL mid_async got v=%b pc=%h ir=%h oen=%b addr=%h halt=%b want 0 0 0 1 0 0", if_valid, if_pc, if_ir, im_oen, im_addr, halt);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_ir !== 32'h1000_0000) begin errors++; $display("FAIL mid_refetch got v=%b pc=%h ir=%h want 1 0 10000000", if_valid, if_pc, if_ir); end
    @(negedge clk);
    checks++; if (if_pc !== 32'h1 || if_ir !== 32'h1000_0001) begin errors++; $display("FAIL mid_refetch2 got pc=%h ir=%h want 1 10000001", if_pc, if_ir); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    test_reset();
    test_straight_line();
    test_stall();
    test_redirect_stall();
    test_pc_wrap();
    test_halt();
    test_wrong_path_halt();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
